// File: rtl/maze_pkg.sv
// Shared types for the maze judge: cell, direction and error codes, FSM states, cell indexing.
package maze_pkg;
  localparam int DIM   = 17;
  localparam int POS_W = 5;
  localparam int IDX_W = 10;

  typedef enum logic [1:0] {
    CELL_PATH    = 2'd0,
    CELL_WALL    = 2'd1,
    CELL_SWORD   = 2'd2,
    CELL_MONSTER = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_WALL    = 2'd1,
    ERR_MONSTER = 2'd2,
    ERR_LIMIT   = 2'd3
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  // Row-major, x fastest.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [POS_W-1:0] x,
                                                input logic [POS_W-1:0] y,
                                                input int dim);
    return IDX_W'(int'(y) * dim + int'(x));
  endfunction
endpackage

// File: rtl/maze_step_check.sv
// Combinational judgement of a single move: target position, legality, error code, sword pickup.
// Out-of-bounds is detected before any update, so the returned position never wraps.
module maze_step_check
  import maze_pkg::*;
#(
  parameter int DIM = maze_pkg::DIM
) (
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  input  dir_t             move,
  input  cell_t            target,
  input  logic             sword,
  output logic [POS_W-1:0] nx,
  output logic [POS_W-1:0] ny,
  output logic             legal,
  output err_t             err,
  output logic             sword_set
);
  localparam logic [POS_W-1:0] LAST = POS_W'(DIM - 1);

  logic oob;

  // Position is kept separate from the verdict: the target cell is looked up from nx/ny.
  always_comb begin
    nx  = x;
    ny  = y;
    oob = 1'b0;
    unique case (move)
      DIR_RIGHT: if (x == LAST) oob = 1'b1; else nx = x + POS_W'(1);
      DIR_DOWN:  if (y == LAST) oob = 1'b1; else ny = y + POS_W'(1);
      DIR_LEFT:  if (x == '0)   oob = 1'b1; else nx = x - POS_W'(1);
      DIR_UP:    if (y == '0)   oob = 1'b1; else ny = y - POS_W'(1);
    endcase
  end

  always_comb begin
    err = ERR_NONE;
    if (oob || target == CELL_WALL)
      err = ERR_WALL;
    else if (target == CELL_MONSTER && !sword)
      err = ERR_MONSTER;
    legal     = (err == ERR_NONE);
    sword_set = legal && (target == CELL_SWORD);
  end
endmodule

// File: rtl/maze_judge.sv
// Loads a DIMxDIM maze from the host, forwards it to the solver with 1-cycle latency, then replays
// the solver's moves and reports a registered verdict. MAZE_JUDGE_STEPS_EN adds the steps counter/limit.
module maze_judge
  import maze_pkg::*;
#(
  parameter int DIM       = maze_pkg::DIM,
  parameter int TIMEOUT   = 1000,
  parameter int MAX_STEPS = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic [1:0] host_cell,
  output logic       maze_valid,
  output logic [1:0] maze_cell,
  input  logic       move_valid,
  input  logic [1:0] move,
  output logic       done,
  output logic       pass,
  output logic [1:0] err
`ifdef MAZE_JUDGE_STEPS_EN
  ,
  output logic [9:0] steps
`endif
);
  localparam int NCELL  = DIM * DIM;
  localparam int AW     = $clog2(NCELL);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(DIM - 1);

  state_t state, state_nxt;

  logic [1:0]        maze [NCELL];
  logic [AW-1:0]     load_idx;
  logic [AW-1:0]     target_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [POS_W-1:0]  pos_x, pos_y, nxt_x, nxt_y;
  logic              sword, legal, sword_set;
  err_t              step_err, verdict_err;
  cell_t             target;
  logic              fwd, load_start, load_last;
  logic              eval, at_exit, step_lim, verdict, verdict_pass, accept;

  assign fwd         = (state == ST_IDLE) || (state == ST_LOAD);
  assign load_start  = (state == ST_IDLE) && host_valid;
  assign load_last   = (load_idx == AW'(NCELL - 1));
  assign target_addr = AW'(cell_idx(nxt_x, nxt_y, DIM));
  // The start cell always reads as open path, whatever the host loaded there.
  assign target      = (target_addr == '0) ? CELL_PATH : cell_t'(maze[target_addr]);

  maze_step_check #(.DIM(DIM)) u_step (
    .x         (pos_x),
    .y         (pos_y),
    .move      (dir_t'(move)),
    .target    (target),
    .sword     (sword),
    .nx        (nxt_x),
    .ny        (nxt_y),
    .legal     (legal),
    .err       (step_err),
    .sword_set (sword_set)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (host_valid) state_nxt = ST_LOAD;
      ST_LOAD:  if (!host_valid) state_nxt = ST_IDLE;
                else if (load_last) state_nxt = ST_WAIT;
      ST_WAIT,
      ST_CHECK: if (verdict) state_nxt = verdict_pass ? ST_IDLE : ST_DRAIN;
                else if (move_valid) state_nxt = ST_CHECK;
      ST_DRAIN: if (!move_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    eval         = ((state == ST_WAIT) || (state == ST_CHECK)) && move_valid;
    at_exit      = (nxt_x == LAST) && (nxt_y == LAST);
    verdict      = 1'b0;
    verdict_pass = 1'b0;
    verdict_err  = ERR_NONE;
    accept       = 1'b0;
    if (eval) begin
      if (step_lim) begin
        verdict     = 1'b1;
        verdict_err = ERR_LIMIT;
      end else if (!legal) begin
        verdict     = 1'b1;
        verdict_err = step_err;
      end else begin
        accept = 1'b1;
        if (at_exit) begin
          verdict      = 1'b1;
          verdict_pass = 1'b1;
        end
      end
    end else if ((state == ST_CHECK) ||
                 ((state == ST_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT)))) begin
      verdict     = 1'b1;
      verdict_err = ERR_LIMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (fwd && host_valid) maze[load_idx] <= host_cell;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_valid <= 1'b0;
      maze_cell  <= 2'd0;
      load_idx   <= '0;
      wait_cnt   <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      sword      <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err        <= 2'd0;
    end else begin
      maze_valid <= fwd && host_valid;
      maze_cell  <= fwd ? host_cell : 2'd0;
      load_idx   <= (fwd && host_valid && !load_last) ? load_idx + AW'(1) : '0;
      wait_cnt   <= (state == ST_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      done       <= verdict;

      if (load_start) begin
        pass <= 1'b0;
        err  <= ERR_NONE;
      end else if (verdict) begin
        pass <= verdict_pass;
        err  <= verdict_err;
      end

      if (fwd) begin
        pos_x <= '0;
        pos_y <= '0;
      end else if (accept) begin
        pos_x <= nxt_x;
        pos_y <= nxt_y;
      end

      if (load_start)
        sword <= 1'b0;
      else if (accept && sword_set)
        sword <= 1'b1;
    end
  end

`ifdef MAZE_JUDGE_STEPS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             steps <= '0;
    else if (load_start) steps <= '0;
    else if (accept)     steps <= steps + 10'd1;
  end
  // steps can never pass MAX_STEPS, so it also saturates there.
  assign step_lim = (steps == 10'(MAX_STEPS));
`else
  assign step_lim = 1'b0;
`endif
endmodule
